// File: rtl/ioctl_loader.sv
// ioctl_loader
//   Turns the byte-wide HPS ioctl download stream into 16-bit word writes.
//   Bytes are paired into words, buffered in a small multi-push FIFO, and
//   written out through a req/ack port.
//
//   Handshake: mem_req rises with the head entry on mem_addr/mem_din/mem_be.
//   All of these hold until mem_ack is seen high on a rising clk_sys edge.
//   That edge completes the transfer. mem_ack is ignored while mem_req=0.
//
//   Ports:
//     clk_sys, reset_n        clock, asynchronous active-low reset
//     ioctl_download/wr/addr/dout/index  HPS byte stream
//     ioctl_wait              registered backpressure (free FIFO entries < 3)
//     mem_addr/din/be/req     word write request, held until mem_ack
//     mem_ack                 one-cycle accept
//     done                    one-cycle pulse when a download is fully written
//     err                     sticky FIFO overflow flag (cleared at download start)
//     cksum                   only with IOCTL_LOADER_CKSUM_EN: mod-256 byte sum
//
//   Optional feature macro: IOCTL_LOADER_CKSUM_EN
module ioctl_loader #(
   parameter int         ADDR_W = 24,
   parameter int         DEPTH  = 8,
   parameter logic [7:0] INDEX  = 8'd0
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_din,
   output logic [1:0]        mem_be,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic              done,
`ifdef IOCTL_LOADER_CKSUM_EN
   output logic [7:0]        cksum,
`endif
   output logic              err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
      logic [1:0]        be;
   } entry_t;

   typedef enum logic [1:0] {C_IDLE, C_LOAD, C_FLUSH} ctrl_t;
   typedef enum logic       {M_IDLE, M_REQ} mem_st_t;

   ctrl_t             r_ctrl, w_ctrl_nxt;
   mem_st_t           r_mem_st, w_mem_st_nxt;
   logic              r_dl_q, r_wait, r_err, r_done, w_done_set;
   logic              r_pend_v, w_pend_v, w_pend_v_nxt;
   logic [ADDR_W-1:0] r_pend_addr, w_pend_addr_nxt;
   logic [7:0]        r_pend_data, w_pend_data_nxt;
   entry_t            r_mem [DEPTH];
   entry_t            w_push0, w_push1, w_pend_ent, w_head;
   logic              w_push0_v, w_push1_v, w_wr0, w_wr1, w_ovf, w_pop;
   logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]     r_count, w_count_nxt;
   logic              w_rise, w_fall, w_acc, w_flush_entry, w_drained;
   logic [ADDR_W-1:0] w_waddr;

   assign w_rise  = ioctl_download & ~r_dl_q;
   assign w_fall  = ~ioctl_download & r_dl_q;
   assign w_acc   = ioctl_download & ioctl_wr & (ioctl_index == INDEX);
   assign w_waddr = ioctl_addr[ADDR_W:1];
   // A new download discards any byte left pending from the previous one.
   assign w_pend_v   = r_pend_v & ~w_rise;
   assign w_pend_ent = '{addr: r_pend_addr, data: {8'h00, r_pend_data}, be: 2'b01};
   assign w_flush_entry = (r_ctrl == C_LOAD) & w_fall;

   // Byte pairing: decides up to two FIFO pushes (push0 always older).
   always_comb begin
      w_push0_v       = 1'b0;
      w_push1_v       = 1'b0;
      w_push0         = w_pend_ent;
      w_push1         = '{addr: w_waddr, data: {ioctl_dout, 8'h00}, be: 2'b10};
      w_pend_v_nxt    = w_pend_v;
      w_pend_addr_nxt = r_pend_addr;
      w_pend_data_nxt = r_pend_data;
      if (w_acc) begin
         if (!ioctl_addr[0]) begin
            w_push0_v       = w_pend_v;
            w_pend_v_nxt    = 1'b1;
            w_pend_addr_nxt = w_waddr;
            w_pend_data_nxt = ioctl_dout;
         end else if (w_pend_v && (r_pend_addr == w_waddr)) begin
            w_push0_v    = 1'b1;
            w_push0      = '{addr: w_waddr, data: {ioctl_dout, r_pend_data}, be: 2'b11};
            w_pend_v_nxt = 1'b0;
         end else begin
            w_pend_v_nxt = 1'b0;
            w_push0_v    = 1'b1;
            if (w_pend_v) w_push1_v = 1'b1;
            else          w_push0   = w_push1;
         end
      end else if (w_flush_entry) begin
         w_push0_v    = w_pend_v;
         w_pend_v_nxt = 1'b0;
      end
   end

   // Full FIFO: pushes that do not fit are dropped (pops this cycle do not
   // make room early, keeping the full check independent of mem_ack).
   assign w_wr0 = w_push0_v & (r_count != CW'(DEPTH));
   assign w_wr1 = w_push1_v & (r_count < CW'(DEPTH - 1));
   assign w_ovf = (w_push0_v & ~w_wr0) | (w_push1_v & ~w_wr1);
   assign w_pop = (r_mem_st == M_REQ) & mem_ack;
   assign w_count_nxt = r_count + CW'(w_wr0) + CW'(w_wr1) - CW'(w_pop);
   assign w_head = r_mem[r_rd_ptr];
   assign w_drained = (r_count == '0) & (r_mem_st == M_IDLE);

   always_ff @(posedge clk_sys) begin
      if (w_wr0) r_mem[r_wr_ptr]           <= w_push0;
      if (w_wr1) r_mem[r_wr_ptr + AW'(1)]  <= w_push1;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_dl_q      <= 1'b0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_pend_v    <= 1'b0;
         r_pend_addr <= '0;
         r_pend_data <= '0;
         r_wait      <= 1'b0;
         r_err       <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_dl_q      <= ioctl_download;
         r_wr_ptr    <= r_wr_ptr + AW'(w_wr0) + AW'(w_wr1);
         r_rd_ptr    <= r_rd_ptr + AW'(w_pop);
         r_count     <= w_count_nxt;
         r_pend_v    <= w_pend_v_nxt;
         r_pend_addr <= w_pend_addr_nxt;
         r_pend_data <= w_pend_data_nxt;
         r_wait      <= (CW'(DEPTH) - r_count) < CW'(3);
         r_done      <= w_done_set;
         if (w_rise) r_err <= 1'b0;
         if (w_ovf)  r_err <= 1'b1;
      end
   end

   // Control FSM: a rising download edge always restarts a load.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) r_ctrl <= C_IDLE;
      else          r_ctrl <= w_ctrl_nxt;
   end

   always_comb begin
      w_ctrl_nxt = r_ctrl;
      w_done_set = 1'b0;
      if (w_rise) begin
         w_ctrl_nxt = C_LOAD;
      end else begin
         case (r_ctrl)
            C_LOAD:  if (w_fall) w_ctrl_nxt = C_FLUSH;
            C_FLUSH: if (w_drained) begin
                        w_ctrl_nxt = C_IDLE;
                        w_done_set = 1'b1;
                     end
            default: w_ctrl_nxt = r_ctrl;
         endcase
      end
   end

   // Memory FSM
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) r_mem_st <= M_IDLE;
      else          r_mem_st <= w_mem_st_nxt;
   end

   always_comb begin
      w_mem_st_nxt = r_mem_st;
      case (r_mem_st)
         M_IDLE:  if (r_count != '0) w_mem_st_nxt = M_REQ;
         M_REQ:   if (w_pop) w_mem_st_nxt = (w_count_nxt != '0) ? M_REQ : M_IDLE;
         default: w_mem_st_nxt = M_IDLE;
      endcase
   end

   // Head is only presented while requesting, so outputs read zero at idle/reset.
   assign mem_req    = (r_mem_st == M_REQ);
   assign mem_addr   = mem_req ? w_head.addr : '0;
   assign mem_din    = mem_req ? w_head.data : '0;
   assign mem_be     = mem_req ? w_head.be   : '0;
   assign ioctl_wait = r_wait;
   assign done       = r_done;
   assign err        = r_err;

`ifdef IOCTL_LOADER_CKSUM_EN
   logic [7:0] r_cksum;
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)   r_cksum <= '0;
      else if (w_rise) r_cksum <= w_acc ? ioctl_dout : 8'h00;
      else if (w_acc)  r_cksum <= r_cksum + ioctl_dout;
   end
   assign cksum = r_cksum;
`endif

endmodule

// File: tb/tb_ioctl_loader.sv
// Directed bench for ioctl_loader: byte pairing, FLUSH push, odd-only
// bytes, backpressure, overflow, mid-transfer reset, zero-byte download,
// and (with IOCTL_LOADER_CKSUM_EN) the checksum.
module tb_ioctl_loader;

  localparam int ADDR_W = 24;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic [7:0]        ioctl_index = '0;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic [1:0]        mem_be;
  logic              mem_req;
  logic              mem_ack = 1'b0;
  logic              done;
  logic              err;
  logic [7:0]        cksum_obs;
`ifdef IOCTL_LOADER_CKSUM_EN
  logic [7:0]        cksum;
  assign cksum_obs = cksum;
`else
  assign cksum_obs = 8'h00;
`endif

  ioctl_loader #(.ADDR_W(ADDR_W), .DEPTH(8), .INDEX(8'd0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
    .mem_req(mem_req), .mem_ack(mem_ack), .done(done),
`ifdef IOCTL_LOADER_CKSUM_EN
    .cksum(cksum),
`endif
    .err(err)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  // scoreboard
  logic [63:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int extra_writes = 0;
  int d0 = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ent(input int a, input logic [15:0] d, input logic [1:0] be);
    logic [ADDR_W-1:0] aa;
    aa = ADDR_W'(a);
    return 64'({aa, d, be});
  endfunction

  // write monitor, sampled on the falling edge (a transfer completes on the next rise)
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) extra_writes++;
        else check_eq("mem_write", 64'({mem_addr, mem_din, mem_be}), exp_q.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input int a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_done(output logic [7:0] ck);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    ck = 8'h00;
    while (!got && n < 300) begin
      @(negedge clk_sys);
      if (done) begin
        got = 1'b1;
        ck = cksum_obs;
      end
      n++;
    end
    check_eq("done_seen", 64'(got), 64'd1);
    tick();
  endtask

  task automatic scn_begin();
    d0 = done_cnt;
    extra_writes = 0;
  endtask

  task automatic scn_end(input int nd);
    check_eq("sb_left", 64'(exp_q.size()), 64'd0);
    check_eq("sb_extra", 64'(extra_writes), 64'd0);
    check_eq("done_cnt", 64'(done_cnt - d0), 64'(nd));
  endtask

  initial begin
    logic [7:0] ck;
    logic [3:0] seq;
    logic seen_wait;
    int tmo;
    int n;

    // reset state
    #2;
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_mem_din", 64'(mem_din), 64'd0);
    check_eq("rst_mem_be", 64'(mem_be), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_wait", 64'(ioctl_wait), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: one full word
    scn_begin();
    mem_ack = 1'b1;
    exp_q.push_back(ent(0, 16'h2211, 2'b11));
    start_dl();
    send_byte(0, 8'h11);
    send_byte(1, 8'h22);
    ioctl_download = 1'b0;
    wait_done(ck);
    repeat (3) tick();
    scn_end(1);

    // 2: three bytes, trailing byte pushed at FLUSH
    scn_begin();
    exp_q.push_back(ent(0, 16'h2211, 2'b11));
    exp_q.push_back(ent(1, 16'h0033, 2'b01));
    start_dl();
    send_byte(0, 8'h11);
    send_byte(1, 8'h22);
    send_byte(2, 8'h33);
    ioctl_download = 1'b0;
    wait_done(ck);
    repeat (3) tick();
    scn_end(1);

    // 3: odd address alone; also a strobe for another index that must be ignored
    scn_begin();
    exp_q.push_back(ent(2, 16'hAB00, 2'b10));
    start_dl();
    ioctl_index = 8'd3;
    send_byte(6, 8'hEE);
    ioctl_index = 8'd0;
    send_byte(5, 8'hAB);
    ioctl_download = 1'b0;
    wait_done(ck);
    repeat (3) tick();
    scn_end(1);

    // 4: backpressure, 20 bytes honouring ioctl_wait with ack stalled
    scn_begin();
    mem_ack = 1'b0;
    for (int k = 0; k < 10; k++)
      exp_q.push_back(ent(k, {8'(8'h41 + 2 * k), 8'(8'h40 + 2 * k)}, 2'b11));
    seen_wait = 1'b0;
    tmo = 0;
    start_dl();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          if (i <= 12 && ioctl_wait) seen_wait = 1'b1;
          n = 0;
          while (ioctl_wait && n < 400) begin
            tick();
            n++;
          end
          if (n >= 400) tmo++;
          send_byte(i, 8'(8'h40 + i));
          tick();
        end
      end
      begin
        repeat (80) tick();
        check_eq("stall_req", 64'(mem_req), 64'd1);
        check_eq("stall_head", 64'({mem_addr, mem_din, mem_be}), ent(0, 16'h4140, 2'b11));
        mem_ack = 1'b1;
      end
    join
    check_eq("wait_by_13th", 64'(seen_wait), 64'd1);
    check_eq("wait_timeout", 64'(tmo), 64'd0);
    check_eq("bp_err", 64'(err), 64'd0);
    ioctl_download = 1'b0;
    wait_done(ck);
    repeat (3) tick();
    scn_end(1);

    // 5: overflow ignoring wait; only the first 8 words survive
    scn_begin();
    mem_ack = 1'b0;
    for (int k = 0; k < 8; k++)
      exp_q.push_back(ent(k, {8'(8'h81 + 2 * k), 8'(8'h80 + 2 * k)}, 2'b11));
    start_dl();
    for (int i = 0; i < 20; i++) send_byte(i, 8'(8'h80 + i));
    tick();
    check_eq("ovf_err_set", 64'(err), 64'd1);
    ioctl_download = 1'b0;
    repeat (3) tick();
    check_eq("ovf_err_sticky", 64'(err), 64'd1);
    start_dl();
    check_eq("ovf_err_clear", 64'(err), 64'd0);
    mem_ack = 1'b1;
    ioctl_download = 1'b0;
    wait_done(ck);
    repeat (3) tick();
    scn_end(1);

    // 6: reset while mem_req is high
    scn_begin();
    mem_ack = 1'b0;
    start_dl();
    send_byte(0, 8'h11);
    send_byte(1, 8'h22);
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check_eq("pre_rst_req", 64'(mem_req), 64'd1);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check_eq("async_rst_req", 64'(mem_req), 64'd0);
    check_eq("async_rst_addr", 64'(mem_addr), 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check_eq("rst_no_done", 64'(done_cnt - d0), 64'd0);
    check_eq("rst_no_write", 64'(extra_writes), 64'd0);
    scn_begin();
    mem_ack = 1'b1;
    exp_q.push_back(ent(8, 16'hA55A, 2'b11));
    start_dl();
    send_byte(16'h10, 8'h5A);
    send_byte(16'h11, 8'hA5);
    ioctl_download = 1'b0;
    wait_done(ck);
    repeat (3) tick();
    scn_end(1);

    // 7: zero-byte download, done one cycle after FLUSH entry
    scn_begin();
    start_dl();
    ioctl_download = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      seq[k] = done;
    end
    tick();
    check_eq("zero_done_seq", 64'(seq), 64'(4'b0100));
    scn_end(1);

`ifdef IOCTL_LOADER_CKSUM_EN
    // 8: checksum wraps modulo 256
    scn_begin();
    exp_q.push_back(ent(0, 16'h02FF, 2'b11));
    start_dl();
    send_byte(0, 8'hFF);
    send_byte(1, 8'h02);
    ioctl_download = 1'b0;
    wait_done(ck);
    check_eq("cksum_at_done", 64'(ck), 64'h01);
    repeat (3) tick();
    scn_end(1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
